// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth floating-point multiplier.
package fp_mul_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_NORM, S_RND, S_DONE, S_SPEC
    } state_t;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef logic signed [2:0] booth_t;

    function automatic booth_t booth_decode(input logic [2:0] triple);
        case (triple)
            3'b001, 3'b010: booth_decode = 3'sd1;
            3'b011:         booth_decode = 3'sd2;
            3'b100:         booth_decode = -3'sd2;
            3'b101, 3'b110: booth_decode = -3'sd1;
            default:        booth_decode = 3'sd0;
        endcase
    endfunction

    function automatic int digits_f(input int frc_w);
        return (frc_w + 3) / 2;
    endfunction

    function automatic int bias_f(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_mul_booth_seq_pp.sv
// Radix-4 Booth partial product: decoded digit times multiplicand, placed at 4^digit.
module fp_booth_r4_pp
    import fp_mul_pkg::*;
#(
    parameter int W     = 24,
    parameter int ACC_W = 50,
    parameter int SH_W  = 4
) (
    input  logic [2:0]       triple,
    input  logic [W-1:0]     mcand,
    input  logic [SH_W-1:0]  digit,
    output logic [ACC_W-1:0] partial
);

    booth_t           d;
    logic [ACC_W-1:0] mag;

    always_comb begin
        d   = booth_decode(triple);
        mag = ACC_W'(mcand);
        if (d == 3'sd2 || d == -3'sd2)
            mag = mag << 1;
        if (d == 3'sd0)
            mag = '0;
        mag     = mag << {digit, 1'b0};
        partial = d[2] ? -mag : mag;
    end

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Sequential IEEE-754 multiplier, one Booth digit per clock, then normalise/round/pack.
// Define FP_MUL_DBG_PRODUCT_EN to expose the raw significand product on frc_Z_full.
module fp_mul_booth_seq
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRC_W:0]   fp_X,
    input  logic [EXP_W+FRC_W:0]   fp_Y,
    input  logic [2:0]             r_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+FRC_W:0]   fp_Z,
    output logic                   ovrf,
    output logic                   udrf
`ifdef FP_MUL_DBG_PRODUCT_EN
    ,
    output logic [2*FRC_W+1:0]     frc_Z_full
`endif
);

    localparam int N     = EXP_W + FRC_W + 1;
    localparam int W     = FRC_W + 1;
    localparam int D     = digits_f(FRC_W);
    localparam int BIAS  = bias_f(EXP_W);
    localparam int ACC_W = 2 * W + 2;
    localparam int MW    = 2 * D + 1;
    localparam int CNT_W = $clog2(D);
    localparam int EW    = EXP_W + 2;
    localparam logic signed [EW-1:0] EMAX_S = EW'(2**EXP_W - 1);

    state_t state, state_d;
    logic [N-1:0]         x_q, y_q, z_q;
    logic [2:0]           rm_q;
    logic [ACC_W-1:0]     acc, partial;
    logic [CNT_W-1:0]     cnt;
    logic signed [EW-1:0] exp_q, exp_n, exp_r;
    logic [FRC_W-1:0]     frac_q;
    logic                 guard_q, sticky_q, ovrf_q, udrf_q;

    logic [EXP_W-1:0] ex_q, ey_q;
    logic [FRC_W-1:0] fx_q, fy_q;
    logic             sign, in_special;
    logic [MW-1:0]    mplr;
    logic [2:0]       triple;
    logic [2*W-1:0]   prod, pn;
    logic [W:0]       mant;
    logic             inc, to_inf, ovf, unf;
    logic [N-1:0]     rnd_z, spec_z;
    logic             unused_bits;

    assign ex_q = x_q[N-2:FRC_W];
    assign ey_q = y_q[N-2:FRC_W];
    assign fx_q = x_q[FRC_W-1:0];
    assign fy_q = y_q[FRC_W-1:0];
    assign sign = x_q[N-1] ^ y_q[N-1];

    // Any all-ones or all-zero exponent bypasses the iteration entirely.
    assign in_special = (&fp_X[N-2:FRC_W]) | (&fp_Y[N-2:FRC_W]) |
                        ~(|fp_X[N-2:FRC_W]) | ~(|fp_Y[N-2:FRC_W]);

    // Leading 0 keeps the recoded multiplier positive; trailing 0 seeds the first triple.
    assign mplr   = MW'({2'b01, fy_q, 1'b0});
    assign triple = mplr[{cnt, 1'b0} +: 3];

    fp_booth_r4_pp #(.W(W), .ACC_W(ACC_W), .SH_W(CNT_W)) u_pp (
        .triple  (triple),
        .mcand   ({1'b1, fx_q}),
        .digit   (cnt),
        .partial (partial)
    );

    assign prod  = acc[2*W-1:0];
    assign pn    = prod[2*W-1] ? prod : prod << 1;
    assign exp_n = EW'({2'b00, ex_q}) + EW'({2'b00, ey_q}) - EW'(BIAS) + EW'(prod[2*W-1]);

    always_comb begin
        case (rm_q)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (guard_q | sticky_q);
            RM_RUP:  inc = ~sign & (guard_q | sticky_q);
            RM_RMM:  inc = guard_q;
            default: inc = guard_q & (sticky_q | frac_q[0]);
        endcase
        to_inf = (rm_q == RM_RTZ) ? 1'b0 : (rm_q == RM_RDN) ? sign :
                 (rm_q == RM_RUP) ? ~sign : 1'b1;
        mant  = {1'b0, 1'b1, frac_q} + (W+1)'(inc);
        exp_r = exp_q + EW'(mant[W]);
        rnd_z = {sign, exp_r[EXP_W-1:0], mant[FRC_W-1:0]};
        ovf   = 1'b0;
        unf   = 1'b0;
        if (exp_r >= EMAX_S) begin
            ovf   = 1'b1;
            rnd_z = to_inf ? {sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}}
                           : {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
        end else if (exp_r[EW-1] || exp_r == '0) begin
            unf   = 1'b1;
            rnd_z = {sign, {(N-1){1'b0}}};
        end
    end

    always_comb begin
        spec_z = {sign, {(N-1){1'b0}}};
        if (((&ex_q) && fx_q != '0) || ((&ey_q) && fy_q != '0) ||
            ((&ex_q) && ey_q == '0) || ((&ey_q) && ex_q == '0))
            spec_z = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRC_W-1){1'b0}}};
        else if ((&ex_q) || (&ey_q))
            spec_z = {sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (in_valid) state_d = in_special ? S_SPEC : S_MUL;
            S_MUL:   if (cnt == CNT_W'(D - 1)) state_d = S_NORM;
            S_NORM:  state_d = S_RND;
            S_RND:   state_d = S_DONE;
            S_SPEC:  state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0; y_q <= '0; rm_q <= '0; acc <= '0; cnt <= '0;
            exp_q <= '0; frac_q <= '0; guard_q <= 1'b0; sticky_q <= 1'b0;
            z_q <= '0; ovrf_q <= 1'b0; udrf_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    x_q <= fp_X; y_q <= fp_Y; rm_q <= r_mode;
                    acc <= '0; cnt <= '0;
                end
                S_MUL: begin
                    acc <= acc + partial;
                    cnt <= cnt + 1'b1;
                end
                S_NORM: begin
                    exp_q    <= exp_n;
                    frac_q   <= pn[2*W-2:W];
                    guard_q  <= pn[W-1];
                    sticky_q <= |pn[W-2:0];
                end
                S_RND:  begin z_q <= rnd_z;  ovrf_q <= ovf;  udrf_q <= unf;  end
                S_SPEC: begin z_q <= spec_z; ovrf_q <= 1'b0; udrf_q <= 1'b0; end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign fp_Z        = z_q;
    assign ovrf        = ovrf_q;
    assign udrf        = udrf_q;
    assign unused_bits = ^{acc[ACC_W-1:2*W], mant[W-1], pn[2*W-1]};

`ifdef FP_MUL_DBG_PRODUCT_EN
    logic spec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           spec_q <= 1'b0;
        else if (state == S_IDLE && in_valid) spec_q <= in_special;
    end

    assign frc_Z_full = (state == S_DONE && !spec_q) ? prod : '0;

    always_comb begin
        if (state == S_DONE && !spec_q)
            assert (prod == (2*W)'({1'b1, fx_q}) * (2*W)'({1'b1, fy_q}));
    end
`endif

endmodule
